// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'b00,
    LAUNCH = 2'b01,
    BUSY   = 2'b10
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int WIDTH_SIZE_DEF     = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin selector starting at ptr
module uart_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] cand;

  // Scan offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (elig[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
        any = 1'b1;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmit path with watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_SIZE     = WIDTH_SIZE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_err,
  input  logic [NUM_REQ-1:0]            req_pf,
  input  logic [NUM_REQ-1:0]            req_enable,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [WIDTH_SIZE-1:0]         tx_data,
  output logic                          tx_err,
  output logic                          tx_pf,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [IW-1:0]                 grant_id,
  output logic                          timeout_flag
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  arb_state_t state, state_n;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] wd;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0] pick_idx;
  logic pick_any;
  logic grant_fire;
  logic timeout_hit;
  logic [WIDTH_SIZE-1:0] sel_data;
  logic sel_err;
  logic sel_pf;

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .elig  (req_valid & req_enable),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Gated by reset so a word is never acked in a cycle whose edge discards it.
  assign grant_fire = (state == ARB) && tx_ready && pick_any && !reset;
  assign req_ready  = grant_fire ? pick_grant : '0;
  assign tx_valid   = (state == LAUNCH);
  assign busy       = (state != ARB);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) sel_data = req_data[i*WIDTH_SIZE +: WIDTH_SIZE];
    end
    sel_err = |(pick_grant & req_err);
    sel_pf  = |(pick_grant & req_pf);
  end

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    case (state)
      ARB:    if (grant_fire) state_n = LAUNCH;
      LAUNCH: state_n = BUSY;
      BUSY: begin
        // wd == 0 marks the first BUSY cycle, where tx_ready may be stale.
        if (wd != '0 && tx_ready) begin
          state_n = ARB;
        end else if (wd == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n     = ARB;
          timeout_hit = 1'b1;
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      wd           <= '0;
      tx_data      <= '0;
      tx_err       <= 1'b0;
      tx_pf        <= 1'b0;
      grant_id     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (grant_fire) begin
        tx_data  <= sel_data;
        tx_err   <= sel_err;
        tx_pf    <= sel_pf;
        grant_id <= pick_idx;
        rr_ptr   <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state == LAUNCH)                wd <= '0;
      else if (state == BUSY && wd != '1) wd <= wd + 1'b1;
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_err = '0, req_pf = '0, req_enable = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic tx_valid, tx_err, tx_pf, busy, timeout_flag;
  logic [W-1:0] tx_data;
  logic tx_ready = 1'b0;
  logic [1:0] grant_id;

  uart_tx_arbiter #(.NUM_REQ(N), .WIDTH_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_err(req_err), .req_pf(req_pf), .req_enable(req_enable),
    .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_err(tx_err), .tx_pf(tx_pf), .tx_ready(tx_ready), .busy(busy),
    .grant_id(grant_id), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int id;
    logic [W-1:0] d;
    logic e;
    logic p;
  } exp_t;

  exp_t sbq[$];
  int dut_log[$];

  // Requester population: each holds its word until accepted.
  logic pend[N];
  logic [W-1:0] pdat[N];
  logic perr[N], ppf[N];
  bit d_reset;
  bit keep_full;
  int txr_mode, gen_pct, wd_pct;
  logic [N-1:0] en;

  // Frame-level reference: 0 idle, 1 launch pulse, 2 frame in flight.
  int m_phase, m_busy, m_ptr;
  bit m_to;

  function automatic int pick(input logic [N-1:0] el, input int ptr);
    for (int k = 0; k < N; k++) if (el[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] el, exp_rdy;
    int w;
    bit txr;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (keep_full || $urandom_range(99) < gen_pct)) begin
        pend[i] = 1'b1;
        pdat[i] = W'($urandom);
        perr[i] = 1'($urandom_range(1));
        ppf[i]  = 1'($urandom_range(1));
      end else if (pend[i] && !keep_full && $urandom_range(99) < wd_pct) begin
        pend[i] = 1'b0;
      end
    end
    case (txr_mode)
      0: txr = 1'b1;
      1: txr = ($urandom_range(3) != 0);
      2: txr = (m_phase == 0);
      default: txr = 1'b0;
    endcase
    reset = d_reset;
    tx_ready = txr;
    req_enable = en;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[i*W +: W] = pdat[i];
      req_err[i] = perr[i];
      req_pf[i] = ppf[i];
      el[i] = pend[i] & en[i];
    end
    #1;
    w = (!d_reset && m_phase == 0 && txr) ? pick(el, m_ptr) : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("tx_valid", 64'(tx_valid), 64'(m_phase == 1));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("timeout_flag", 64'(timeout_flag), 64'(m_to));
    if (d_reset) begin
      m_phase = 0; m_ptr = 0; m_to = 0; m_busy = 0;
      sbq.delete();
    end else begin
      case (m_phase)
        0: if (w >= 0) begin
          sbq.push_back('{w, pdat[w], perr[w], ppf[w]});
          pend[w] = 1'b0;
          m_ptr = (w + 1) % N;
          m_phase = 1;
        end
        1: begin m_phase = 2; m_busy = 1; end
        default: begin
          if (m_busy >= 2 && txr) m_phase = 0;
          else if (m_busy == TO) begin m_phase = 0; m_to = 1; end
          else m_busy++;
        end
      endcase
    end
  endtask

  task automatic do_reset();
    d_reset = 1'b1;
    step();
    d_reset = 1'b0;
    dut_log.delete();
  endtask

  // Monitor: pops the scoreboard on each launch and checks the word stays held.
  logic [W-1:0] last_d;
  bit have_last = 0;
  exp_t e;
  initial forever begin
    @(negedge clk);
    #2;
    if (reset) begin
      have_last = 0;
    end else if (tx_valid) begin
      chk("sb_depth", 64'(sbq.size()), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("tx_data", 64'(tx_data), 64'(e.d));
        chk("tx_err", 64'(tx_err), 64'(e.e));
        chk("tx_pf", 64'(tx_pf), 64'(e.p));
        chk("grant_id", 64'(grant_id), 64'(e.id));
        dut_log.push_back(int'(grant_id));
        last_d = e.d;
        have_last = 1;
      end
    end else if (busy && have_last) begin
      chk("tx_data_hold", 64'(tx_data), 64'(last_d));
    end
  end

  initial begin
    int order4[5] = '{0, 1, 2, 3, 0};
    int order2[3] = '{1, 3, 1};
    int n;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pdat[i] = 0; perr[i] = 0; ppf[i] = 0; end
    en = '1; gen_pct = 0; wd_pct = 0; keep_full = 0; txr_mode = 3; d_reset = 1;
    m_phase = 0; m_ptr = 0; m_to = 0; m_busy = 0;
    step(); step();
    d_reset = 0;
    step();
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_err", 64'(tx_err), 64'd0);
    chk("rst_tx_pf", 64'(tx_pf), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    // Single requester 1 with A5.
    pend[1] = 1; pdat[1] = 8'hA5; perr[1] = 0; ppf[1] = 1;
    txr_mode = 0;
    step();
    chk("single_ready", 64'(req_ready), 64'b0010);
    step();
    chk("single_data", 64'(tx_data), 64'hA5);
    repeat (6) step();

    // All four continuously from reset.
    do_reset();
    keep_full = 1;
    repeat (22) step();
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(dut_log.size() > k ? dut_log[k] : -1), 64'(order4[k]));

    // Enable mask 1010.
    do_reset();
    en = 4'b1010;
    repeat (14) step();
    for (int k = 0; k < 3; k++) chk("mask_order", 64'(dut_log.size() > k ? dut_log[k] : -1), 64'(order2[k]));

    // Watchdog: transmit path never returns ready.
    keep_full = 0; en = '1;
    for (int i = 0; i < N; i++) pend[i] = 0;
    do_reset();
    pend[0] = 1; pdat[0] = 8'h3C;
    txr_mode = 2;
    repeat (70) step();
    chk("timeout_set", 64'(timeout_flag), 64'd1);
    pend[0] = 1; pend[1] = 1; pdat[1] = 8'h5A;
    txr_mode = 0;
    repeat (3) step();
    chk("after_timeout_grant", 64'(dut_log.size() > 1 ? dut_log[1] : -1), 64'd1);

    // Reset while a frame is in flight.
    keep_full = 1;
    n = 0;
    while (m_phase != 2 && n < 10) begin step(); n++; end
    chk("reached_busy", 64'(busy), 64'd1);
    keep_full = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    do_reset();
    step();
    chk("rst2_outputs", 64'({req_ready, tx_valid, tx_data, tx_err, tx_pf, busy, grant_id, timeout_flag}), 64'd0);
    pend[2] = 1; pdat[2] = 8'h77;
    step();
    chk("rst2_grant", 64'(req_ready), 64'b0100);
    repeat (5) step();

    // Randomized traffic.
    gen_pct = 40; wd_pct = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        en = N'($urandom);
        txr_mode = $urandom_range(2);
      end
      d_reset = ($urandom_range(299) == 0);
      step();
    end
    d_reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
